// File: rtl/wbu.sv
// Writeback unit: retires EXU results into the register file.
// Loads park in WAIT_MEM until read data returns, then extend it.
module wbu #(
  parameter int CPU_WIDTH = 32,
  parameter int RADDR_W   = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CPU_WIDTH-1:0] in_pc,
  input  logic [RADDR_W-1:0]   in_rd,
  input  logic                 in_rd_wen,
  input  logic [CPU_WIDTH-1:0] in_alu_res,
  input  logic                 in_is_load,
  input  logic [2:0]           in_funct3,
  input  logic                 mem_rvalid,
  input  logic [CPU_WIDTH-1:0] mem_rdata,
  output logic                 rf_wen,
  output logic [RADDR_W-1:0]   rf_waddr,
  output logic [CPU_WIDTH-1:0] rf_wdata,
  output logic                 retire_valid,
  output logic [CPU_WIDTH-1:0] retire_pc,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic                 err
);

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } state_t;

  state_t state, state_nxt;

  logic [RADDR_W-1:0]   ld_rd;
  logic                 ld_wen;
  logic [2:0]           ld_f3;
  logic [1:0]           ld_lo;
  logic [CPU_WIDTH-1:0] ld_pc;

  logic                 xfer;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [CPU_WIDTH-1:0] ld_data;
  logic                 ld_bad;

  assign in_ready = (state == IDLE);
  assign xfer     = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: loads wait for the read response, ALU ops never leave IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (xfer && in_is_load) state_nxt = WAIT_MEM;
      WAIT_MEM: if (mem_rvalid)         state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Select the addressed byte/halfword and extend per the load code.
  always_comb begin
    ld_byte = 8'h00;
    ld_half = 16'h0000;
    ld_data = '0;
    ld_bad  = 1'b0;
    case (ld_lo)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = ld_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_f3)
      3'b000:  ld_data = {{(CPU_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(CPU_WIDTH-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(CPU_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(CPU_WIDTH-16){1'b0}}, ld_half};
      3'b010:  ld_data = mem_rdata;
      default: ld_bad  = 1'b1;
    endcase
  end

  // Registered writeback, retire, load context and error tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen       <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      retire_valid <= 1'b0;
      retire_pc    <= '0;
      retire_cnt   <= '0;
      err          <= 1'b0;
      ld_rd        <= '0;
      ld_wen       <= 1'b0;
      ld_f3        <= 3'b000;
      ld_lo        <= 2'b00;
      ld_pc        <= '0;
    end else begin
      rf_wen       <= 1'b0;
      retire_valid <= 1'b0;
      retire_cnt   <= retire_cnt + CNT_W'(retire_valid);
      if (state == IDLE) begin
        if (mem_rvalid) err <= 1'b1;
        if (xfer) begin
          if (in_is_load) begin
            ld_rd  <= in_rd;
            ld_wen <= in_rd_wen;
            ld_f3  <= in_funct3;
            ld_lo  <= in_alu_res[1:0];
            ld_pc  <= in_pc;
          end else begin
            rf_wen       <= in_rd_wen && (in_rd != '0);
            rf_waddr     <= in_rd;
            rf_wdata     <= in_alu_res;
            retire_valid <= 1'b1;
            retire_pc    <= in_pc;
          end
        end
      end else if (mem_rvalid) begin
        rf_wen       <= ld_wen && (ld_rd != '0);
        rf_waddr     <= ld_rd;
        rf_wdata     <= ld_data;
        retire_valid <= 1'b1;
        retire_pc    <= ld_pc;
        if (ld_bad) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: ALU path, load extension, reset-abort,
// rd=0 suppression, sticky error and counter wrap (CNT_W = 4).
module tb_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [31:0] in_alu_res;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [3:0]  retire_cnt;
  logic        err;

  int nvec = 0;
  int nerr = 0;

  wbu #(.CPU_WIDTH(32), .RADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_alu_res(in_alu_res), .in_is_load(in_is_load),
    .in_funct3(in_funct3),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_cnt(retire_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res,
                     input logic [31:0] pc);
    in_valid   = 1'b1;
    in_is_load = 1'b0;
    in_rd      = rd;
    in_rd_wen  = 1'b1;
    in_alu_res = res;
    in_pc      = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] exp_d, input logic exp_w);
    int low;
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_funct3  = f3;
    in_rd      = rd;
    in_rd_wen  = 1'b1;
    in_alu_res = {30'h0400_0000, lo};
    in_pc      = pc;
    tick();
    in_valid = 1'b0;
    chk({tag, "_acc_wen"}, 32'(rf_wen), 32'd0);
    chk({tag, "_acc_ret"}, 32'(retire_valid), 32'd0);
    low = 0;
    mem_rdata = rdata;
    for (int i = 0; i < 5; i++) begin
      if (!in_ready) low++;
      if (i == 4) mem_rvalid = 1'b1;
      tick();
    end
    mem_rvalid = 1'b0;
    chk({tag, "_ready_low"}, 32'(low), 32'd5);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_wen"}, 32'(rf_wen), 32'(exp_w));
    chk({tag, "_waddr"}, 32'(rf_waddr), 32'(rd));
    chk({tag, "_wdata"}, rf_wdata, exp_d);
    chk({tag, "_ret"}, 32'(retire_valid), 32'd1);
    chk({tag, "_rpc"}, retire_pc, pc);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_rd = '0;
    in_rd_wen = 1'b0; in_alu_res = '0; in_is_load = 1'b0;
    in_funct3 = 3'b000; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wen", 32'(rf_wen), 32'd0);
    chk("rst_ret", 32'(retire_valid), 32'd0);
    chk("rst_cnt", 32'(retire_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_rpc", retire_pc, 32'd0);

    // Three back-to-back ALU transfers.
    in_valid = 1'b1; in_is_load = 1'b0; in_rd_wen = 1'b1;
    in_rd = 5'd1; in_alu_res = 32'h11; in_pc = 32'h8000_0000;
    tick();
    chk("a1_wen", 32'(rf_wen), 32'd1);
    chk("a1_waddr", 32'(rf_waddr), 32'd1);
    chk("a1_wdata", rf_wdata, 32'h11);
    chk("a1_rpc", retire_pc, 32'h8000_0000);
    in_rd = 5'd2; in_alu_res = 32'h22; in_pc = 32'h8000_0004;
    tick();
    chk("a2_wen", 32'(rf_wen), 32'd1);
    chk("a2_wdata", rf_wdata, 32'h22);
    chk("a2_cnt", 32'(retire_cnt), 32'd1);
    in_rd = 5'd3; in_alu_res = 32'h33; in_pc = 32'h8000_0008;
    tick();
    chk("a3_wen", 32'(rf_wen), 32'd1);
    chk("a3_waddr", 32'(rf_waddr), 32'd3);
    chk("a3_wdata", rf_wdata, 32'h33);
    chk("a3_rpc", retire_pc, 32'h8000_0008);
    in_valid = 1'b0;
    tick();
    chk("idle_wen", 32'(rf_wen), 32'd0);
    chk("idle_ret", 32'(retire_valid), 32'd0);
    chk("idle_hold", rf_wdata, 32'h33);
    chk("a_cnt3", 32'(retire_cnt), 32'd3);

    // Load extension.
    do_load("lb", 3'b000, 2'd3, 32'h80FF_7F01, 5'd4,
            32'h8000_0010, 32'hFFFF_FF80, 1'b1);
    do_load("lbu", 3'b100, 2'd3, 32'h80FF_7F01, 5'd6,
            32'h8000_0014, 32'h0000_0080, 1'b1);
    do_load("lh", 3'b001, 2'd2, 32'h8001_1234, 5'd7,
            32'h8000_0018, 32'hFFFF_8001, 1'b1);
    do_load("lhu", 3'b101, 2'd2, 32'h8001_1234, 5'd8,
            32'h8000_001C, 32'h0000_8001, 1'b1);
    do_load("lw", 3'b010, 2'd0, 32'h80FF_7F01, 5'd9,
            32'h8000_0020, 32'h80FF_7F01, 1'b1);
    tick();
    chk("ld_cnt8", 32'(retire_cnt), 32'd8);
    chk("ld_err", 32'(err), 32'd0);

    // rd = 0 retires without writing.
    alu(5'd0, 32'hDEAD_BEEF, 32'h8000_0024);
    chk("r0_wen", 32'(rf_wen), 32'd0);
    chk("r0_ret", 32'(retire_valid), 32'd1);
    chk("r0_rpc", retire_pc, 32'h8000_0024);
    tick();
    chk("r0_cnt9", 32'(retire_cnt), 32'd9);

    // Reset during WAIT_MEM, then a stray read response.
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'b010;
    in_rd = 5'd10; in_alu_res = 32'h100; in_pc = 32'h8000_0028;
    tick();
    in_valid = 1'b0;
    chk("rm_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_cnt", 32'(retire_cnt), 32'd0);
    chk("rm_ready2", 32'(in_ready), 32'd1);
    chk("rm_err0", 32'(err), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    chk("rm_wen", 32'(rf_wen), 32'd0);
    chk("rm_ret", 32'(retire_valid), 32'd0);
    chk("rm_err1", 32'(err), 32'd1);
    tick();
    chk("rm_cnt2", 32'(retire_cnt), 32'd0);
    chk("rm_err_sticky", 32'(err), 32'd1);

    // Undefined load code writes zero and flags an error.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("bad_err0", 32'(err), 32'd0);
    do_load("bad", 3'b011, 2'd1, 32'hFFFF_FFFF, 5'd5,
            32'h8000_002C, 32'h0000_0000, 1'b1);
    chk("bad_err1", 32'(err), 32'd1);
    tick(); tick();
    chk("bad_sticky", 32'(err), 32'd1);

    // Counter wrap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 15; k++)
      alu(5'd1, 32'(k), 32'h9000_0000 + 32'(4 * k));
    tick();
    chk("wrap_15", 32'(retire_cnt), 32'd15);
    alu(5'd2, 32'hA, 32'h9000_1000);
    alu(5'd3, 32'hB, 32'h9000_1004);
    tick();
    chk("wrap_1", 32'(retire_cnt), 32'd1);
    chk("wrap_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wbu.md
Name: wbu

Overview:
- Writeback unit. Sits directly upstream of the register file and drives its write port (`en`/`waddr`/`wdata`).
- Accepts completed instructions from EXU over a valid/ready handshake. ALU results pass straight through.
- For loads, waits for the memory read response, then byte/half-extends the data. Emits one retire pulse per instruction, used by the simulation difftest and the trap check.

Parameters:
- CPU_WIDTH, 32, datapath width.
- RADDR_W, 5, register address width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EXU offers an instruction
- in_ready  out  1  WBU can accept this cycle
- in_pc  in  CPU_WIDTH  PC of the offered instruction
- in_rd  in  RADDR_W  destination register
- in_rd_wen  in  1  instruction writes rd
- in_alu_res  in  CPU_WIDTH  ALU result / load address
- in_is_load  in  1  instruction is a load
- in_funct3  in  3  load width/sign code
- mem_rvalid  in  1  memory read data valid (single-cycle pulse)
- mem_rdata  in  CPU_WIDTH  word-aligned read data
- rf_wen  out  1  register-file write enable
- rf_waddr  out  RADDR_W  register-file write address
- rf_wdata  out  CPU_WIDTH  register-file write data
- retire_valid  out  1  one-cycle pulse per completed instruction
- retire_pc  out  CPU_WIDTH  PC of the retiring instruction
- retire_cnt  out  CNT_W  count of retired instructions
- err  out  1  sticky protocol/decode error flag

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - All outputs 0, except in_ready, which is 1 in IDLE.
  - State is IDLE; retire_cnt = 0; err = 0.
  - Reset mid-load drops the pending load with no write and no retire.
- FSM has two states, IDLE and WAIT_MEM.
- in_ready = (state == IDLE). A transfer is in_valid && in_ready.
- IDLE, transfer with in_is_load = 0:
  - Next cycle: rf_wen = in_rd_wen && (in_rd != 0), rf_waddr = in_rd, rf_wdata = in_alu_res, retire_valid = 1, retire_pc = in_pc.
  - Stay in IDLE. Back-to-back transfers every cycle are allowed (throughput 1/cycle, latency 1).
- IDLE, transfer with in_is_load = 1:
  - Latch rd, rd_wen, funct3, alu_res[1:0] and pc; go to WAIT_MEM.
  - No write or retire on this transfer.
- WAIT_MEM, mem_rvalid = 1:
  - Next cycle: rf_wen (same rd != 0 rule), extended data, retire_valid = 1, retire_pc = latched pc.
  - Return to IDLE. New instructions can be accepted starting that same cycle.
- WAIT_MEM, mem_rvalid = 0: hold; no timeout.
- mem_rvalid while IDLE: ignore the data; set err.
- Load extension (lo = latched alu_res[1:0]):
  - 000 LB: byte lo, sign-extended.
  - 100 LBU: byte lo, zero-extended.
  - 001 LH: halfword lo[1], sign-extended; lo[0] ignored.
  - 101 LHU: halfword lo[1], zero-extended.
  - 010 LW: full word.
  - Any other code: write data 0 (still written if rd_wen), set err.
- rf_wen, rf_waddr, rf_wdata, retire_valid and retire_pc are registered.
  - When no event occurs: rf_wen = 0 and retire_valid = 0; rf_waddr, rf_wdata and retire_pc hold their last values.
- retire_cnt increments on each retire_valid cycle (visible the cycle after the pulse) and wraps modulo 2^CNT_W.
- rd = 0 with rd_wen = 1: no write, but the instruction still retires.
- err clears only on rst.

Test Plan:
- Reset, then drive 3 consecutive non-load transfers (rd = 1, 2, 3; res = 0x11, 0x22, 0x33; pc = 0x80000000 + 4k) → rf_wen high for 3 consecutive cycles starting 1 cycle after the first transfer, with matching data; retire_cnt reaches 3.
- LB with lo = 3, mem_rdata = 0x80FF7F01, mem_rvalid 4 cycles after the transfer → in_ready low for 5 cycles; rf_wdata = 0xFFFFFF80 one cycle after rvalid. Repeat with LBU → 0x00000080.
- LH/LHU with lo = 2, mem_rdata = 0x8001xxxx → LH writes 0xFFFF8001, LHU writes 0x00008001. LW with lo = 0 → exact word.
- Transfer with rd = 0, rd_wen = 1, res = 0xDEADBEEF → rf_wen stays 0; retire_valid pulses; retire_cnt increments.
- Assert rst during WAIT_MEM, then pulse mem_rvalid → no write, no retire, err = 1 (rvalid arrived in IDLE); retire_cnt = 0.
- Load with funct3 = 011 and rd = 5 → rf_wdata = 0, rf_wen = 1, err = 1 sticky. Preload retire_cnt near 2^CNT_W − 1 (force or small CNT_W) and retire twice → counter wraps to 1.
